button_gesture: RTL and testbench

//  Classifies a clean, synchronized button level into gesture events: short press,

---
 rtl/button_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 27 ++
 rtl/button_gesture.sv | 125 ++++++++++++
 tb/tb_button_gesture.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared FSM state encoding and counter width for the button gesture block
package button_pkg;

    localparam int TCNT_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRESS1 = ST_PRESS1,
        WAIT2  = ST_WAIT2,
        PRESS2 = ST_PRESS2,
        HOLD   = ST_HOLD
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running 2**PWR_2 divider emitting a 1-cycle tick enable
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-low
//   tick   out  1-cycle strobe each time the counter wraps
module tick_prescaler #(
    parameter int PWR_2 = 17
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [PWR_2-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PWR_2'(1);
        end
    end

    // All-ones is the last count before the wrap, so the tick coincides with it.
    assign tick = &cnt;

endmodule

// File: rtl/button_gesture.sv
// rtl/button_gesture.sv - classifies a clean button level into short/double/long/repeat strobes
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-low
//   btn       in   debounced, synchronized button level (1 = pressed)
//   short_o   out  1-cycle strobe: single press released before long, no second press
//   double_o  out  1-cycle strobe: second press released
//   long_o    out  1-cycle strobe: first press held LONG_TICKS
//   repeat_o  out  1-cycle strobe every REPEAT_TICKS while held after long_o
//   busy_o    out  level, high whenever a gesture is in progress
module button_gesture
    import button_pkg::*;
#(
    parameter int TICK_PWR2    = 17,
    parameter int LONG_TICKS   = 64,
    parameter int DCLICK_TICKS = 24,
    parameter int REPEAT_TICKS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic short_o,
    output logic double_o,
    output logic long_o,
    output logic repeat_o,
    output logic busy_o
);

    localparam logic [TCNT_W:0] LONG_CMP   = (TCNT_W+1)'(LONG_TICKS);
    localparam logic [TCNT_W:0] DCLICK_CMP = (TCNT_W+1)'(DCLICK_TICKS);
    localparam logic [TCNT_W:0] REPEAT_CMP = (TCNT_W+1)'(REPEAT_TICKS);

    state_t            state, state_d;
    logic [TCNT_W-1:0] tcnt;
    logic [TCNT_W:0]   tcnt_inc;
    logic              btn_q, rise, fall, tick;
    logic              tcnt_clr;
    logic              short_d, double_d, long_d, repeat_d;

    tick_prescaler #(.PWR_2(TICK_PWR2)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;

    // One bit wider so a saturated count can never alias onto a threshold.
    assign tcnt_inc = {1'b0, tcnt} + (TCNT_W+1)'(1);

    // Edges are tested before ticks in every state: an edge landing on a
    // timeout tick wins and the timeout event is dropped.
    always_comb begin
        state_d  = state;
        tcnt_clr = 1'b0;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_d = WAIT2;
                end else if (tick && tcnt_inc == LONG_CMP) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            WAIT2: begin
                if (rise) begin
                    state_d = PRESS2;
                end else if (tick && tcnt_inc == DCLICK_CMP) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            HOLD: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (tick && tcnt_inc == REPEAT_CMP) begin
                    repeat_d = 1'b1;
                    tcnt_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // btn_q tracks btn even in reset so a press held through reset is not a rise.
        btn_q <= btn;
        if (!reset) begin
            state    <= IDLE;
            tcnt     <= '0;
            short_o  <= 1'b0;
            double_o <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
        end else begin
            state    <= state_d;
            short_o  <= short_d;
            double_o <= double_d;
            long_o   <= long_d;
            repeat_o <= repeat_d;
            if (state_d != state || tcnt_clr) begin
                tcnt <= '0;
            end else if (tick && tcnt != '1) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_button_gesture.sv
// tb/tb_button_gesture.sv - directed self-checking bench for button_gesture
module tb_button_gesture;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn = 1'b0;
    logic short_o, double_o, long_o, repeat_o, busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    int ei = 0;
    int c_short, c_double, c_long, c_rep;
    int f_short, f_double, f_long, f_rep, l_rep;
    bit multi;

    button_gesture #(
        .TICK_PWR2    (2),
        .LONG_TICKS   (8),
        .DCLICK_TICKS (4),
        .REPEAT_TICKS (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .short_o  (short_o),
        .double_o (double_o),
        .long_o   (long_o),
        .repeat_o (repeat_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        c_short = 0; c_double = 0; c_long = 0; c_rep = 0;
        f_short = -1; f_double = -1; f_long = -1; f_rep = -1; l_rep = -1;
        multi = 1'b0;
    endtask

    // Edge index ei counts posedges since the last reset edge (E0).
    task automatic step();
        @(posedge clk);
        ei++;
        #1;
        if (short_o === 1'b1) begin c_short++; if (f_short < 0) f_short = ei; end
        if (double_o === 1'b1) begin c_double++; if (f_double < 0) f_double = ei; end
        if (long_o === 1'b1) begin c_long++; if (f_long < 0) f_long = ei; end
        if (repeat_o === 1'b1) begin c_rep++; if (f_rep < 0) f_rep = ei; l_rep = ei; end
        if (int'(short_o) + int'(double_o) + int'(long_o) + int'(repeat_o) > 1) multi = 1'b1;
    endtask

    task automatic hold(input logic v, input int n);
        btn = v;
        repeat (n) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        ei = 0;
        clear_counts();
    endtask

    task automatic test_reset();
        btn = 1'b0;
        reset = 1'b0;
        step();
        step();
        n_cmp++;
        if ({short_o, double_o, long_o, repeat_o, busy_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00000", {short_o, double_o, long_o, repeat_o, busy_o});
        end
    endtask

    task automatic test_short();
        do_reset();
        hold(1'b1, 12);
        hold(1'b0, 40);
        n_cmp++;
        if (c_short !== 1 || f_short !== 28) begin
            n_bad++;
            $display("FAIL short_event: got count %0d at E%0d want 1 at E28", c_short, f_short);
        end
        n_cmp++;
        if (c_double + c_long + c_rep !== 0 || multi) begin
            n_bad++;
            $display("FAIL short_others: got %0d other strobes multi=%0d want 0", c_double + c_long + c_rep, multi);
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL short_busy_end: got %b want 0", busy_o);
        end
    endtask

    task automatic test_double();
        do_reset();
        hold(1'b1, 8);
        hold(1'b0, 6);
        hold(1'b1, 8);
        hold(1'b0, 30);
        n_cmp++;
        if (c_double !== 1 || f_double !== 23) begin
            n_bad++;
            $display("FAIL double_event: got count %0d at E%0d want 1 at E23", c_double, f_double);
        end
        n_cmp++;
        if (c_short + c_long + c_rep !== 0 || multi) begin
            n_bad++;
            $display("FAIL double_others: got %0d other strobes multi=%0d want 0", c_short + c_long + c_rep, multi);
        end
    endtask

    task automatic test_long_repeat();
        do_reset();
        hold(1'b1, 80);
        n_cmp++;
        if (c_long !== 1 || f_long !== 32) begin
            n_bad++;
            $display("FAIL long_event: got count %0d at E%0d want 1 at E32", c_long, f_long);
        end
        n_cmp++;
        if (c_rep !== 6 || f_rep !== 40 || l_rep !== 80) begin
            n_bad++;
            $display("FAIL repeat_events: got %0d first E%0d last E%0d want 6 first E40 last E80", c_rep, f_rep, l_rep);
        end
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_busy: got %b want 1", busy_o);
        end
        hold(1'b0, 20);
        n_cmp++;
        if (c_long !== 1 || c_rep !== 6 || c_short + c_double !== 0 || multi) begin
            n_bad++;
            $display("FAIL release_after_hold: got long %0d rep %0d other %0d multi %0d want 1 6 0 0", c_long, c_rep, c_short + c_double, multi);
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_held_through_reset();
        btn = 1'b1;
        do_reset();
        hold(1'b1, 5);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL held_reset_busy: got %b want 0", busy_o);
        end
        hold(1'b0, 10);
        hold(1'b1, 8);
        hold(1'b0, 30);
        n_cmp++;
        if (c_short !== 1 || f_short !== 40 || c_double + c_long + c_rep !== 0) begin
            n_bad++;
            $display("FAIL held_reset_short: got short %0d at E%0d others %0d want 1 at E40 others 0", c_short, f_short, c_double + c_long + c_rep);
        end
    endtask

    task automatic test_reset_mid_gesture();
        do_reset();
        hold(1'b1, 4);
        hold(1'b0, 3);
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL wait2_busy: got %b want 1", busy_o);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({short_o, double_o, long_o, repeat_o, busy_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %b want 00000", {short_o, double_o, long_o, repeat_o, busy_o});
        end
        reset = 1'b1;
        hold(1'b0, 30);
        n_cmp++;
        if (c_short + c_double + c_long + c_rep !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_events: got %0d strobes want 0", c_short + c_double + c_long + c_rep);
        end
    endtask

    task automatic test_timeout_exact();
        do_reset();
        hold(1'b1, 8);
        hold(1'b0, 20);
        n_cmp++;
        if (c_short !== 1 || f_short !== 24) begin
            n_bad++;
            $display("FAIL dclick_timeout: got count %0d at E%0d want 1 at E24", c_short, f_short);
        end
    endtask

    task automatic test_edge_vs_tick();
        do_reset();
        hold(1'b1, 8);
        hold(1'b0, 15);
        hold(1'b1, 8);
        hold(1'b0, 20);
        n_cmp++;
        if (c_double !== 1 || f_double !== 32) begin
            n_bad++;
            $display("FAIL edge_wins_double: got count %0d at E%0d want 1 at E32", c_double, f_double);
        end
        n_cmp++;
        if (c_short + c_long + c_rep !== 0) begin
            n_bad++;
            $display("FAIL edge_wins_no_short: got %0d other strobes want 0", c_short + c_long + c_rep);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_short();
        test_double();
        test_long_repeat();
        test_held_through_reset();
        test_reset_mid_gesture();
        test_timeout_exact();
        test_edge_vs_tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
